// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// master drives requests (start, bin); slave returns status and digits.
interface bin2bcd_seq_if #(
  parameter int unsigned W = 9
);
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         valid;
  logic [3:0]   bcd0;
  logic [3:0]   bcd1;
  logic [3:0]   bcd2;

  modport master (
    output start, bin,
    input  busy, done, valid, bcd0, bcd1, bcd2
  );

  modport slave (
    input  start, bin,
    output busy, done, valid, bcd0, bcd1, bcd2
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: W-bit unsigned binary to three BCD digits,
// one adjust-and-shift per clock. Optional macro BIN2BCD_AUTO_EN adds auto-start on input change.
module bin2bcd_seq #(
  parameter int unsigned W = 9
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SR_W  = BCD_W + W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sreg_q, sreg_d;
  logic [SR_W-1:0]    sreg_adj_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [3:0]         bcd0_q, bcd0_d;
  logic [3:0]         bcd1_q, bcd1_d;
  logic [3:0]         bcd2_q, bcd2_d;
  logic               go_c;
  logic               last_iter_c;

  // Add 3 to every BCD digit >= 5, then shift the whole register left by one.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[W + 4*d +: 4] >= 4'd5) begin
        t[W + 4*d +: 4] = t[W + 4*d +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  assign sreg_adj_c  = dabble(sreg_q);
  assign last_iter_c = (cnt_q == CNT_W'(1));

`ifdef BIN2BCD_AUTO_EN
  logic [W-1:0] last_q, last_d;
  logic [W-1:0] cap_q, cap_d;

  // Restart whenever nothing has been converted yet or the input moved.
  assign go_c = bus.start | ~valid_q | (bus.bin != last_q);
`else
  assign go_c = bus.start;
`endif

  // State and datapath registers; synchronous reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bcd0_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd2_q  <= 4'd0;
`ifdef BIN2BCD_AUTO_EN
      last_q  <= '0;
      cap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
`ifdef BIN2BCD_AUTO_EN
      last_q  <= last_d;
      cap_q   <= cap_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go_c)        state_d = CONV;
      CONV: if (last_iter_c) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    bcd0_d  = bcd0_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
`ifdef BIN2BCD_AUTO_EN
    last_d  = last_q;
    cap_d   = cap_q;
`endif
    case (state_q)
      IDLE: begin
        if (go_c) begin
          sreg_d = {BCD_W'(0), bus.bin};
          cnt_d  = CNT_W'(W);
          busy_d = 1'b1;
`ifdef BIN2BCD_AUTO_EN
          cap_d  = bus.bin;
`endif
        end
      end
      CONV: begin
        sreg_d = sreg_adj_c;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_iter_c) begin
          // Digits are published only here, so they never show partial shifts.
          bcd0_d  = sreg_adj_c[W +: 4];
          bcd1_d  = sreg_adj_c[W + 4 +: 4];
          bcd2_d  = sreg_adj_c[W + 8 +: 4];
          done_d  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
`ifdef BIN2BCD_AUTO_EN
          last_d  = cap_q;
`endif
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.bcd0  = bcd0_q;
  assign bus.bcd1  = bcd1_q;
  assign bus.bcd2  = bcd2_q;

endmodule
